// File: rtl/fir_pkg.sv
// Shared definitions for the FIR output path: state encoding, default widths
// and ap_ctrl status bit positions.
package fir_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_CNT_WIDTH  = 32;

  localparam int unsigned AP_DONE_BIT = 1;
  localparam int unsigned AP_IDLE_BIT = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/fir_sm_out_buf_if.sv
// Result input port (valid/ready) plus AXI-Stream master toward the host.
interface fir_sm_out_buf_if #(
  parameter int unsigned DW = 32
);
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic          sm_tvalid;
  logic          sm_tready;
  logic [DW-1:0] sm_tdata;
  logic          sm_tlast;

  // slave: the output buffer itself; master: the surrounding FIR core / sink
  modport slave (
    input  res_valid, res_data, sm_tready,
    output res_ready, sm_tvalid, sm_tdata, sm_tlast
  );
  modport master (
    output res_valid, res_data, sm_tready,
    input  res_ready, sm_tvalid, sm_tdata, sm_tlast
  );
endinterface

// File: rtl/fir_sync_fifo.sv
// Show-ahead synchronous FIFO; pointers carry one extra wrap bit so that
// full/empty are distinguished without an occupancy counter.
module fir_sync_fifo #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [DW-1:0] r_mem [DEPTH];
  logic          w_push;
  logic          w_pop;

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= din;
        r_wr_ptr                <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  assign dout  = r_mem[r_rd_ptr[AW-1:0]];
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
endmodule

// File: rtl/fir_sm_out_buf.sv
// FIR output buffer: FIFOs results, streams them on sm_*, tags the final
// sample with tlast and reports done/idle. FIR_OUT_STALL_STAT_EN adds stall_cnt.
module fir_sm_out_buf
  import fir_pkg::*;
#(
  parameter int unsigned pDATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned pDEPTH      = 4,
  parameter int unsigned pCNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  axis_clk,
  input  logic                  axis_rst_n,
  input  logic                  start,
  input  logic [pCNT_WIDTH-1:0] cfg_length,
  fir_sm_out_buf_if.slave       bus,
  output logic                  done,
  output logic                  idle,
  output logic [pCNT_WIDTH-1:0] out_cnt
`ifdef FIR_OUT_STALL_STAT_EN
  ,
  output logic [pCNT_WIDTH-1:0] stall_cnt
`endif
);
  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [pCNT_WIDTH-1:0]   r_len_q;
  logic [pCNT_WIDTH-1:0]   r_in_cnt;
  logic [pCNT_WIDTH-1:0]   r_out_cnt;
  logic                    r_done;
  logic                    r_idle;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_start_ok;
  logic                    w_in_hs;
  logic                    w_out_hs;
  logic                    w_last_hs;
  logic [pDATA_WIDTH-1:0]  w_head;

  fir_sync_fifo #(
    .DW    (pDATA_WIDTH),
    .DEPTH (pDEPTH)
  ) u_fifo (
    .clk   (axis_clk),
    .rst_n (axis_rst_n),
    .push  (w_in_hs),
    .pop   (w_out_hs),
    .din   (bus.res_data),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_start_ok    = start & (r_state == S_IDLE);
  assign bus.res_ready = (r_state == S_RUN) & ~w_full & (r_in_cnt < r_len_q);
  assign bus.sm_tvalid = ~w_empty & ((r_state == S_RUN) | (r_state == S_DRAIN));
  assign bus.sm_tdata  = w_head;
  assign bus.sm_tlast  = bus.sm_tvalid & (r_out_cnt == r_len_q - pCNT_WIDTH'(1));
  assign w_in_hs       = bus.res_valid & bus.res_ready;
  assign w_out_hs      = bus.sm_tvalid & bus.sm_tready;
  assign w_last_hs     = w_out_hs & bus.sm_tlast;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) r_state <= S_IDLE;
    else             r_state <= w_state_nxt;
  end

  // The tlast handshake can already land in RUN when the sink keeps pace.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = (cfg_length == '0) ? S_DONE : S_RUN;
      S_RUN: begin
        if (w_last_hs)                   w_state_nxt = S_DONE;
        else if (r_in_cnt == r_len_q)    w_state_nxt = S_DRAIN;
      end
      S_DRAIN: if (w_last_hs) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_len_q   <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_done    <= 1'b0;
      r_idle    <= 1'b1;
    end else begin
      r_done <= (w_state_nxt == S_DONE);
      r_idle <= (w_state_nxt == S_IDLE);
      if (w_start_ok) begin
        r_len_q   <= cfg_length;
        r_in_cnt  <= '0;
        r_out_cnt <= '0;
      end else begin
        if (w_in_hs)  r_in_cnt  <= r_in_cnt + pCNT_WIDTH'(1);
        if (w_out_hs) r_out_cnt <= r_out_cnt + pCNT_WIDTH'(1);
      end
    end
  end

  assign done    = r_done;
  assign idle    = r_idle;
  assign out_cnt = r_out_cnt;

`ifdef FIR_OUT_STALL_STAT_EN
  logic [pCNT_WIDTH-1:0] r_stall_cnt;

  // Saturating count of sink back-pressure cycles, held after done.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_start_ok) begin
      r_stall_cnt <= '0;
    end else if (bus.sm_tvalid && !bus.sm_tready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + pCNT_WIDTH'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_fir_sm_out_buf.sv
// Randomized self-checking bench for fir_sm_out_buf; the reference model is a
// queue of accepted results plus accepted/emitted counts.
module tb_fir_sm_out_buf;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 32;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] cfg_length;
  logic          done;
  logic          idle;
  logic [CW-1:0] out_cnt;
`ifdef FIR_OUT_STALL_STAT_EN
  logic [CW-1:0] stall_cnt;
`endif

  int n_checks;
  int n_pass;

  fir_sm_out_buf_if #(.DW(DW)) bus ();

  fir_sm_out_buf #(
    .pDATA_WIDTH (DW),
    .pDEPTH      (DEPTH),
    .pCNT_WIDTH  (CW)
  ) dut (
    .axis_clk   (clk),
    .axis_rst_n (rst_n),
    .start      (start),
    .cfg_length (cfg_length),
    .bus        (bus),
    .done       (done),
    .idle       (idle),
    .out_cnt    (out_cnt)
`ifdef FIR_OUT_STALL_STAT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive at negedge, check 1 time unit later, handshakes resolve at posedge.
  task automatic run_stream(input int len, input int vprob, input int rprob,
                            input int hold, input bit seq, input string name);
    logic [DW-1:0] q[$];
    int acc, outs, cyc, stalls;
    bit prev_stall, exp_ready, exp_valid;
    logic [DW-1:0] prev_data;
    logic prev_last;
    acc = 0; outs = 0; cyc = 0; stalls = 0; prev_stall = 0;
    prev_data = '0; prev_last = 0;
    @(negedge clk);
    start = 1'b1; cfg_length = CW'(len);
    bus.res_valid = 1'b0; bus.sm_tready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (outs < len && cyc < len * 40 + 200) begin
      bus.res_valid = (acc < len) && ($urandom_range(99) < vprob);
      bus.res_data  = seq ? DW'(acc + 1) : DW'($urandom);
      bus.sm_tready = (cyc >= hold) && ($urandom_range(99) < rprob);
      #1;
      exp_ready = (acc < len) && ((acc - outs) < int'(DEPTH));
      exp_valid = (acc > outs);
      n_checks++;
      if (bus.res_ready !== exp_ready)
        $display("FAIL %s res_ready cyc %0d: got %b exp %b", name, cyc, bus.res_ready, exp_ready);
      else n_pass++;
      n_checks++;
      if (bus.sm_tvalid !== exp_valid)
        $display("FAIL %s sm_tvalid cyc %0d: got %b exp %b", name, cyc, bus.sm_tvalid, exp_valid);
      else n_pass++;
      if (exp_valid) begin
        n_checks++;
        if (bus.sm_tdata !== q[outs])
          $display("FAIL %s sm_tdata idx %0d: got %h exp %h", name, outs, bus.sm_tdata, q[outs]);
        else n_pass++;
        n_checks++;
        if (bus.sm_tlast !== (outs == len - 1))
          $display("FAIL %s sm_tlast idx %0d: got %b exp %b", name, outs, bus.sm_tlast, (outs == len - 1));
        else n_pass++;
      end
      if (prev_stall) begin
        n_checks++;
        if (bus.sm_tdata !== prev_data || bus.sm_tlast !== prev_last || bus.sm_tvalid !== 1'b1)
          $display("FAIL %s stall_hold cyc %0d: got %h/%b exp %h/%b", name, cyc,
                   bus.sm_tdata, bus.sm_tlast, prev_data, prev_last);
        else n_pass++;
      end
      n_checks++;
      if (done !== 1'b0 || idle !== 1'b0)
        $display("FAIL %s busy_status cyc %0d: got done %b idle %b exp 0 0", name, cyc, done, idle);
      else n_pass++;
      prev_stall = exp_valid && !bus.sm_tready;
      prev_data  = bus.sm_tdata;
      prev_last  = bus.sm_tlast;
      if (prev_stall) stalls++;
      if (bus.res_valid && exp_ready) begin
        q.push_back(bus.res_data);
        acc++;
      end
      if (exp_valid && bus.sm_tready) outs++;
      cyc++;
      @(negedge clk);
    end
    bus.res_valid = 1'b0; bus.sm_tready = 1'b0;
    n_checks++;
    if (outs != len) $display("FAIL %s timeout: got %0d outputs exp %0d", name, outs, len);
    else n_pass++;
    #1;
    n_checks++;
    if (done !== 1'b1 || idle !== 1'b0 || out_cnt !== CW'(len))
      $display("FAIL %s done_cycle: got done %b idle %b out_cnt %0d exp 1 0 %0d", name, done, idle, out_cnt, len);
    else n_pass++;
`ifdef FIR_OUT_STALL_STAT_EN
    n_checks++;
    if (stall_cnt !== CW'(stalls))
      $display("FAIL %s stall_cnt: got %0d exp %0d", name, stall_cnt, stalls);
    else n_pass++;
`endif
    @(negedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || idle !== 1'b1 || out_cnt !== CW'(len) || bus.sm_tvalid !== 1'b0 || bus.res_ready !== 1'b0)
      $display("FAIL %s after_done: got done %b idle %b out_cnt %0d tvalid %b ready %b exp 0 1 %0d 0 0",
               name, done, idle, out_cnt, bus.sm_tvalid, bus.res_ready, len);
    else n_pass++;
`ifdef FIR_OUT_STALL_STAT_EN
    n_checks++;
    if (stall_cnt !== CW'(stalls))
      $display("FAIL %s stall_cnt_hold: got %0d exp %0d", name, stall_cnt, stalls);
    else n_pass++;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; cfg_length = '0;
    bus.res_valid = 1'b0; bus.res_data = '0; bus.sm_tready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (idle !== 1'b1 || done !== 1'b0 || out_cnt !== '0 || bus.sm_tvalid !== 1'b0 ||
        bus.sm_tlast !== 1'b0 || bus.sm_tdata !== '0 || bus.res_ready !== 1'b0)
      $display("FAIL reset_values: got idle %b done %b out_cnt %0d tvalid %b tlast %b tdata %h ready %b",
               idle, done, out_cnt, bus.sm_tvalid, bus.sm_tlast, bus.sm_tdata, bus.res_ready);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_stream(5, 100, 100, 0, 1'b1, "basic");
  endtask

  task automatic test_backpressure();
    run_stream(8, 100, 100, 12, 1'b1, "backpressure");
  endtask

  task automatic test_zero_len();
    @(negedge clk);
    start = 1'b1; cfg_length = '0;
    @(negedge clk);
    start = 1'b0;
    #1;
    n_checks++;
    if (done !== 1'b1 || idle !== 1'b0 || bus.res_ready !== 1'b0 || bus.sm_tvalid !== 1'b0)
      $display("FAIL zero_len_done: got done %b idle %b ready %b tvalid %b exp 1 0 0 0",
               done, idle, bus.res_ready, bus.sm_tvalid);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if (done !== 1'b0 || idle !== 1'b1 || bus.res_ready !== 1'b0 || bus.sm_tvalid !== 1'b0)
        $display("FAIL zero_len_idle %0d: got done %b idle %b ready %b tvalid %b exp 0 1 0 0",
                 i, done, idle, bus.res_ready, bus.sm_tvalid);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    run_stream(600, 100, 100, 0, 1'b0, "wrap600");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      run_stream(int'($urandom_range(40, 1)), 60, 50, 0, 1'b0, "random");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; cfg_length = CW'(10);
    @(negedge clk);
    start = 1'b0;
    bus.res_valid = 1'b1; bus.sm_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.res_data = DW'(32'hA0 + i);
      @(negedge clk);
    end
    bus.res_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (idle !== 1'b1 || done !== 1'b0 || out_cnt !== '0 || bus.sm_tvalid !== 1'b0 ||
        bus.sm_tlast !== 1'b0 || bus.res_ready !== 1'b0)
      $display("FAIL reset_mid_async: got idle %b done %b out_cnt %0d tvalid %b tlast %b ready %b",
               idle, done, out_cnt, bus.sm_tvalid, bus.sm_tlast, bus.res_ready);
    else n_pass++;
    @(negedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || bus.sm_tvalid !== 1'b0)
      $display("FAIL reset_mid_hold: got done %b tvalid %b exp 0 0", done, bus.sm_tvalid);
    else n_pass++;
    #2 rst_n = 1'b1;
    run_stream(2, 100, 100, 0, 1'b1, "post_reset");
  endtask

`ifdef FIR_OUT_STALL_STAT_EN
  task automatic test_stall();
    run_stream(3, 100, 100, 5, 1'b1, "stall");
    n_checks++;
    if (stall_cnt !== CW'(4)) $display("FAIL stall_fixed: got %0d exp 4", stall_cnt);
    else n_pass++;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_len();
    test_wrap();
    test_random();
    test_reset_mid();
`ifdef FIR_OUT_STALL_STAT_EN
    test_stall();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
